baud_frac_generator: RTL and testbench

BAUD_FRAC_GENERATOR -- requirements
Module: baud_frac_generator

---
 rtl/baud_frac_generator_pkg.sv | 23 ++
 rtl/baud_frac_generator_frac_prescaler.sv | 50 +++++
 rtl/baud_frac_generator.sv | 102 ++++++++++
 tb/tb_baud_frac_generator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_frac_generator_pkg.sv
// Shared UART constants: divisor legality limits and default baud divisors
// for 100 MHz / 50 MHz clocks at OVS=16, DIV_FRAC_W=4 (value = clk / baud / 16).
package baud_frac_generator_pkg;

  localparam int UART_MIN_DIV = 2;
  localparam int UART_OVS_MIN = 4;
  localparam int UART_OVS_MAX = 32;

  typedef struct packed {
    logic [15:0] div_int;
    logic [3:0]  div_frac;
  } uart_div_t;

  localparam uart_div_t DIV_100M_4800   = '{div_int: 16'd1302, div_frac: 4'd1};
  localparam uart_div_t DIV_100M_9600   = '{div_int: 16'd651,  div_frac: 4'd1};
  localparam uart_div_t DIV_100M_57600  = '{div_int: 16'd108,  div_frac: 4'd8};
  localparam uart_div_t DIV_100M_115200 = '{div_int: 16'd54,   div_frac: 4'd4};
  localparam uart_div_t DIV_50M_4800    = '{div_int: 16'd651,  div_frac: 4'd1};
  localparam uart_div_t DIV_50M_9600    = '{div_int: 16'd325,  div_frac: 4'd8};
  localparam uart_div_t DIV_50M_57600   = '{div_int: 16'd54,   div_frac: 4'd4};
  localparam uart_div_t DIV_50M_115200  = '{div_int: 16'd27,   div_frac: 4'd2};

endpackage

// File: rtl/baud_frac_generator_frac_prescaler.sv
// Fractional prescaler: period of div_int + carry cycles, divisor latched at period start.
// tc is combinational and high in the last cycle of each period; clr/!en hold the phase at 0.
module frac_prescaler #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tc
);

  localparam logic [INT_W:0] ONE = (INT_W+1)'(1);

  logic [INT_W:0]  cnt;
  logic [INT_W:0]  per_len;
  logic [INT_W:0]  len_now;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;
  logic            start;

  always_comb begin
    start   = (cnt == '0);
    sum     = {1'b0, acc} + {1'b0, div_frac};
    // The divisor only matters at period start; mid-period we follow the latched length.
    len_now = start ? ({1'b0, div_int} + {{INT_W{1'b0}}, sum[FRAC_W]}) : per_len;
    tc      = en && !clr && (cnt == len_now - ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      per_len <= '0;
    end else if (!en || clr) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + ONE;
      if (start) begin
        per_len <= len_now;
        acc     <= sum[FRAC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/baud_frac_generator.sv
// UART baud generator: rx oversampling tick and tx bit tick from one fractional divisor.
// Ticks are registered (one cycle after terminal count); new divisors apply at rx boundaries.
module baud_frac_generator
  import baud_frac_generator_pkg::*;
#(
  parameter int DIV_INT_W    = 16,
  parameter int DIV_FRAC_W   = 4,
  parameter int OVS          = 16,
  parameter int RST_DIV_INT  = 1302,
  parameter int RST_DIV_FRAC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_en,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic                  div_load,
  input  logic                  rx_resync,
  output logic                  rx_tick,
  output logic                  tx_tick,
  output logic                  cfg_err,
  output logic                  load_pending
);

  localparam int SUB_W = $clog2(OVS);
  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(OVS - 1);
  localparam logic [SUB_W-1:0]      SUB_ONE  = SUB_W'(1);
  localparam logic [DIV_INT_W-1:0]  RST_INT  = DIV_INT_W'(RST_DIV_INT);
  localparam logic [DIV_FRAC_W-1:0] RST_FRAC = DIV_FRAC_W'(RST_DIV_FRAC);
  localparam logic [DIV_INT_W-1:0]  MIN_DIV  = DIV_INT_W'(UART_MIN_DIV);

  logic [DIV_INT_W-1:0]  act_int, sh_int;
  logic [DIV_FRAC_W-1:0] act_frac, sh_frac;
  logic [SUB_W-1:0]      sub;
  logic                  rx_tc, tx_tc;
  logic                  div_ok, apply;

  assign div_ok = (div_int >= MIN_DIV);
  // Pending is a register, so a load coinciding with a terminal count waits one boundary.
  assign apply  = load_pending && (rx_tc || rx_resync || !uart_en);

  frac_prescaler #(.INT_W(DIV_INT_W), .FRAC_W(DIV_FRAC_W)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .en       (uart_en),
    .clr      (rx_resync),
    .div_int  (act_int),
    .div_frac (act_frac),
    .tc       (rx_tc)
  );

  frac_prescaler #(.INT_W(DIV_INT_W), .FRAC_W(DIV_FRAC_W)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .en       (uart_en),
    .clr      (1'b0),
    .div_int  (act_int),
    .div_frac (act_frac),
    .tc       (tx_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      act_int      <= RST_INT;
      act_frac     <= RST_FRAC;
      sh_int       <= RST_INT;
      sh_frac      <= RST_FRAC;
      load_pending <= 1'b0;
      cfg_err      <= 1'b0;
      rx_tick      <= 1'b0;
      tx_tick      <= 1'b0;
      sub          <= '0;
    end else begin
      rx_tick <= rx_tc;
      tx_tick <= tx_tc && (sub == SUB_LAST);

      if (!uart_en) begin
        sub <= '0;
      end else if (tx_tc) begin
        sub <= (sub == SUB_LAST) ? '0 : sub + SUB_ONE;
      end

      if (apply) begin
        act_int      <= sh_int;
        act_frac     <= sh_frac;
        load_pending <= 1'b0;
      end

      if (div_load) begin
        if (div_ok) begin
          sh_int       <= div_int;
          sh_frac      <= div_frac;
          load_pending <= 1'b1;
          cfg_err      <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_frac_generator.sv
// Directed bench for baud_frac_generator: tick spacing, fractional periods, divisor loading,
// resync and mid-run reset, with hand-computed expected cycle offsets.
module tb_baud_frac_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_en = 1'b0;
  logic [15:0] div_int = 16'd0;
  logic [3:0]  div_frac = 4'd0;
  logic        div_load = 1'b0;
  logic        rx_resync = 1'b0;
  logic        rx_tick, tx_tick, cfg_err, load_pending;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  baud_frac_generator dut (
    .clk          (clk),
    .rst          (rst),
    .uart_en      (uart_en),
    .div_int      (div_int),
    .div_frac     (div_frac),
    .div_load     (div_load),
    .rx_resync    (rx_resync),
    .rx_tick      (rx_tick),
    .tx_tick      (tx_tick),
    .cfg_err      (cfg_err),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int budget, output int t);
    int i;
    t = -1;
    i = 0;
    while (t < 0 && i < budget) begin
      step();
      if (rx_tick) t = cyc;
      i++;
    end
  endtask

  task automatic wait_tx(input int budget, output int t);
    int i;
    t = -1;
    i = 0;
    while (t < 0 && i < budget) begin
      step();
      if (tx_tick) t = cyc;
      i++;
    end
  endtask

  // Disable, load a divisor (applied while disabled), re-enable; e = cycle uart_en rises.
  task automatic restart(input int di, input int df, output int e);
    uart_en = 1'b0;
    step();
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    step();
    step();
    uart_en = 1'b1;
    e = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    step();
    checks++;
    if (rx_tick !== 1'b0) begin failures++; $display("FAIL reset_rx_tick got %b expected 0", rx_tick); end
    checks++;
    if (tx_tick !== 1'b0) begin failures++; $display("FAIL reset_tx_tick got %b expected 0", tx_tick); end
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got %b expected 0", cfg_err); end
    checks++;
    if (load_pending !== 1'b0) begin failures++; $display("FAIL reset_load_pending got %b expected 0", load_pending); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_int_div();
    int e, rx_cnt, bad, tx_cnt, tx_first;
    restart(4, 0, e);
    rx_cnt = 0; bad = 0; tx_cnt = 0; tx_first = -1;
    for (int k = 1; k <= 128; k++) begin
      step();
      if (rx_tick) begin
        rx_cnt++;
        if (k % 4 != 0) bad++;
      end
      if (tx_tick) begin
        tx_cnt++;
        if (tx_first < 0) tx_first = k;
      end
    end
    checks++;
    if (rx_cnt !== 32) begin failures++; $display("FAIL int_rx_count got %0d expected 32", rx_cnt); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL int_rx_phase got %0d off-grid ticks expected 0", bad); end
    checks++;
    if (tx_cnt !== 2) begin failures++; $display("FAIL int_tx_count got %0d expected 2", tx_cnt); end
    checks++;
    if (tx_first !== 64) begin failures++; $display("FAIL int_tx_first got %0d expected 64", tx_first); end
  endtask

  // Periods 4,5,4,5,... -> ticks at offsets 4, 9, 13, 18, ..., 144.
  task automatic test_frac();
    int e, n, first, second, last;
    restart(4, 8, e);
    n = 0; first = -1; second = -1; last = -1;
    for (int k = 1; k <= 144; k++) begin
      step();
      if (rx_tick) begin
        n++;
        if (n == 1) first = k;
        if (n == 2) second = k;
        last = k;
      end
    end
    checks++;
    if (n !== 32) begin failures++; $display("FAIL frac_count got %0d expected 32", n); end
    checks++;
    if (first !== 4) begin failures++; $display("FAIL frac_first got %0d expected 4", first); end
    checks++;
    if (second !== 9) begin failures++; $display("FAIL frac_second got %0d expected 9", second); end
    checks++;
    if (last !== 144) begin failures++; $display("FAIL frac_last got %0d expected 144", last); end
  endtask

  task automatic test_cfg_err();
    int e, t0, t1, t2, t3, t4, t5;
    restart(4, 0, e);
    wait_rx(20, t0);
    checks++;
    if (t0 !== e + 4) begin failures++; $display("FAIL cfg_first_tick got %0d expected %0d", t0, e + 4); end
    div_int = 16'd1; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_set got %b expected 1", cfg_err); end
    checks++;
    if (load_pending !== 1'b0) begin failures++; $display("FAIL cfg_bad_pending got %b expected 0", load_pending); end
    wait_rx(20, t1);
    wait_rx(20, t2);
    checks++;
    if (t2 - t1 !== 4) begin failures++; $display("FAIL cfg_bad_spacing got %0d expected 4", t2 - t1); end
    div_int = 16'd6; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_clear got %b expected 0", cfg_err); end
    checks++;
    if (load_pending !== 1'b1) begin failures++; $display("FAIL cfg_good_pending got %b expected 1", load_pending); end
    wait_rx(20, t3);
    checks++;
    if (t3 - t2 !== 4) begin failures++; $display("FAIL cfg_old_period got %0d expected 4", t3 - t2); end
    checks++;
    if (load_pending !== 1'b0) begin failures++; $display("FAIL cfg_pending_clear got %b expected 0", load_pending); end
    wait_rx(20, t4);
    wait_rx(20, t5);
    checks++;
    if (t4 - t3 !== 6) begin failures++; $display("FAIL cfg_new_period1 got %0d expected 6", t4 - t3); end
    checks++;
    if (t5 - t4 !== 6) begin failures++; $display("FAIL cfg_new_period2 got %0d expected 6", t5 - t4); end
  endtask

  task automatic test_load_at_tc();
    int e, t0, t1, t2;
    restart(4, 0, e);
    wait_rx(20, t0);
    step(); step(); step();
    div_int = 16'd8; div_load = 1'b1;   // this cycle is the rx terminal count
    step();
    div_load = 1'b0;
    checks++;
    if (rx_tick !== 1'b1) begin failures++; $display("FAIL tc_tick got %b expected 1", rx_tick); end
    checks++;
    if (load_pending !== 1'b1) begin failures++; $display("FAIL tc_pending got %b expected 1", load_pending); end
    wait_rx(20, t1);
    checks++;
    if (t1 !== t0 + 8) begin failures++; $display("FAIL tc_old_once got %0d expected %0d", t1, t0 + 8); end
    checks++;
    if (load_pending !== 1'b0) begin failures++; $display("FAIL tc_pending_clear got %b expected 0", load_pending); end
    wait_rx(20, t2);
    checks++;
    if (t2 - t1 !== 8) begin failures++; $display("FAIL tc_new_period got %0d expected 8", t2 - t1); end
  endtask

  // Counter restarts the cycle after the resync pulse, so the next tick lands 11 cycles after the pulse.
  task automatic test_resync();
    int e, t0, r, t1, r2, t2, tx;
    restart(10, 0, e);
    wait_rx(30, t0);
    checks++;
    if (t0 !== e + 10) begin failures++; $display("FAIL rs_first got %0d expected %0d", t0, e + 10); end
    step(); step(); step();
    r = cyc;
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    wait_rx(30, t1);
    checks++;
    if (t1 !== r + 11) begin failures++; $display("FAIL rs_restart got %0d expected %0d", t1, r + 11); end
    for (int k = 0; k < 9; k++) step();
    r2 = cyc;
    rx_resync = 1'b1;                   // coincides with the rx terminal count
    step();
    rx_resync = 1'b0;
    checks++;
    if (rx_tick !== 1'b0) begin failures++; $display("FAIL rs_suppress got %b expected 0", rx_tick); end
    wait_rx(30, t2);
    checks++;
    if (t2 !== r2 + 11) begin failures++; $display("FAIL rs_after_tc got %0d expected %0d", t2, r2 + 11); end
    wait_tx(200, tx);
    checks++;
    if (tx !== e + 160) begin failures++; $display("FAIL rs_tx_phase got %0d expected %0d", tx, e + 160); end
  endtask

  task automatic test_reset_mid();
    int e, t0, s, t1;
    restart(10, 0, e);
    wait_rx(30, t0);
    div_int = 16'd7; div_load = 1'b1;
    step();
    div_int = 16'd1;
    step();
    div_load = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin failures++; $display("FAIL rm_pre_cfg_err got %b expected 1", cfg_err); end
    checks++;
    if (load_pending !== 1'b1) begin failures++; $display("FAIL rm_pre_pending got %b expected 1", load_pending); end
    for (int k = 0; k < 7; k++) step();
    rst = 1'b1;                         // lands on an rx terminal count
    step();
    checks++;
    if (rx_tick !== 1'b0) begin failures++; $display("FAIL rm_rx_tick got %b expected 0", rx_tick); end
    checks++;
    if (tx_tick !== 1'b0) begin failures++; $display("FAIL rm_tx_tick got %b expected 0", tx_tick); end
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL rm_cfg_err got %b expected 0", cfg_err); end
    checks++;
    if (load_pending !== 1'b0) begin failures++; $display("FAIL rm_pending got %b expected 0", load_pending); end
    rst = 1'b0;
    s = cyc;
    wait_rx(1400, t1);
    checks++;
    if (t1 !== s + 1302) begin failures++; $display("FAIL rm_first_tick got %0d expected %0d", t1, s + 1302); end
  endtask

  initial begin
    test_reset();
    test_int_div();
    test_frac();
    test_cfg_err();
    test_load_at_tc();
    test_resync();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
